// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: FSM state encodings, serial
// line levels and parity type codes, plus a small parity helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;

   // xor_all is the XOR of all data bits, which is already the even-parity bit;
   // odd parity is simply its complement.
   function automatic logic parity_bit(input logic xor_all, input logic par_typ);
      return (par_typ == PAR_EVEN) ? xor_all : ~xor_all;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Holds the word being transmitted and a bit counter, and selects the data
// bit that the top-level output register should load next.
// Ports:
//   clk_TX    in   TX baud clock
//   rst       in   async active-low reset
//   load      in   latch din and clear the bit counter
//   shift_en  in   advance to the next data bit
//   din       in   parallel word (DATAWIDTH bits)
//   ser_bit   out  data bit the line carries in the next cycle
//   ser_done  out  the last data bit is currently on the line
//   par_bit   out  XOR of the latched word (even-parity bit)
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int DATAWIDTH = 8
) (
   input  logic                 clk_TX,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 shift_en,
   input  logic [DATAWIDTH-1:0] din,
   output logic                 ser_bit,
   output logic                 ser_done,
   output logic                 par_bit
);

   localparam int CW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(DATAWIDTH - 1);

   logic [DATAWIDTH-1:0] data_q, data_d;
   logic [CW-1:0]        cnt_q,  cnt_d;

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (load) begin
         data_d = din;
         cnt_d  = '0;
      end else if (shift_en && (cnt_q != LAST_IDX)) begin
         // Saturating: the counter stops at the last bit index.
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_TX or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   // The line output is registered in the top, so the bit it loads must be the
   // one selected by the post-update counter value, not the current one.
   assign ser_bit  = data_q[cnt_d];
   assign ser_done = (cnt_q == LAST_IDX);
   assign par_bit  = ^data_q;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter. Accepts a word on DATA_VALID while idle and sends one
// frame: start bit, DATAWIDTH data bits LSB first, optional parity, one stop
// bit. One bit per clk_TX cycle. TX_OUT and busy are registered.
// Ports:
//   clk_TX      in   TX baud clock, one bit period per cycle
//   rst         in   async active-low reset
//   P_DATA      in   parallel word to send
//   DATA_VALID  in   P_DATA valid; accepted only while busy==0
//   PAR_EN      in   1 = append parity bit
//   PAR_TYP     in   0 = even parity, 1 = odd parity
//   TX_OUT      out  serial line, idles high
//   busy        out  frame in progress
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATAWIDTH = 8
) (
   input  logic                 clk_TX,
   input  logic                 rst,
   input  logic [DATAWIDTH-1:0] P_DATA,
   input  logic                 DATA_VALID,
   input  logic                 PAR_EN,
   input  logic                 PAR_TYP,
   output logic                 TX_OUT,
   output logic                 busy
);

   tx_state_e state_q, state_d;
   logic      tx_q, tx_d;
   logic      busy_q, busy_d;
   logic      par_en_q, par_en_d;
   logic      par_typ_q, par_typ_d;

   logic      load;
   logic      shift_en;
   logic      ser_bit;
   logic      ser_done;
   logic      par_bit;

   uart_tx_serializer #(
      .DATAWIDTH (DATAWIDTH)
   ) u_ser (
      .clk_TX   (clk_TX),
      .rst      (rst),
      .load     (load),
      .shift_en (shift_en),
      .din      (P_DATA),
      .ser_bit  (ser_bit),
      .ser_done (ser_done),
      .par_bit  (par_bit)
   );

   // state_q names what the line is carrying this cycle; tx_d/busy_d are the
   // line values for the state being entered, so outputs change on the same
   // edge as the state and acceptance-to-start-bit latency is one cycle.
   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      load      = 1'b0;
      shift_en  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d   = LINE_IDLE;
            busy_d = 1'b0;
            if (DATA_VALID) begin
               load      = 1'b1;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
               state_d   = ST_START;
               tx_d      = START_LVL;
               busy_d    = 1'b1;
            end
         end
         ST_START: begin
            state_d = ST_DATA;
            tx_d    = ser_bit;
            busy_d  = 1'b1;
         end
         ST_DATA: begin
            busy_d = 1'b1;
            if (ser_done) begin
               if (par_en_q) begin
                  state_d = ST_PARITY;
                  tx_d    = parity_bit(par_bit, par_typ_q);
               end else begin
                  state_d = ST_STOP;
                  tx_d    = STOP_LVL;
               end
            end else begin
               shift_en = 1'b1;
               tx_d     = ser_bit;
            end
         end
         ST_PARITY: begin
            state_d = ST_STOP;
            tx_d    = STOP_LVL;
            busy_d  = 1'b1;
         end
         ST_STOP: begin
            // Requests during STOP are ignored; the next word is taken in IDLE.
            state_d = ST_IDLE;
            tx_d    = LINE_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = LINE_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_TX or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         tx_q      <= LINE_IDLE;
         busy_q    <= 1'b0;
         par_en_q  <= 1'b0;
         par_typ_q <= PAR_EVEN;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
      end
   end

   assign TX_OUT = tx_q;
   assign busy   = busy_q;

endmodule
